ifu_fd_stage: RTL
=================

Name: ifu_fd_stage

Overview:
- Fetch-stage PC register plus F/D pipeline register of the 5-stage MIPS core.
- Holds F_PC and drives the instruction-memory word address from it.
- Captures the fetched instruction and its PC into D-stage registers.
- Each cycle it takes F_nextPC from the next-PC logic as the new F_PC, unless stalled by the hazard unit.
- Supports stall (hold both F_PC and F/D) and flush (insert a bubble into D).

Parameters:
- RESET_PC, 32'h0000_3000, value loaded into F_PC on reset.
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- IM_AW, 12, instruction-memory word-address width (4096 words).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- resetn  in  1  synchronous active-low reset.
- F_nextPC  in  32  next fetch address from next-PC logic.
- stall  in  1  hazard-unit stall; holds F_PC and the F/D register.
- flush  in  1  clears the F/D register to a bubble.
- im_addr  out  IM_AW  instruction-memory word address, combinational from F_PC.
- im_rdata  in  32  instruction word; combinational read, valid in the same cycle as im_addr.
- F_PC  out  32  current fetch PC; next-PC logic consumes it.
- D_instr  out  32  instruction in D.
- D_PC  out  32  PC of D_instr.
- D_valid  out  1  1 when D holds a real instruction, 0 for a bubble.
- stall_cnt  out  32  saturating count of stalled cycles since reset.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetn, sampled only at posedge clk.
- Reset values (resetn=0 at posedge):
  - F_PC = RESET_PC.
  - D_instr = 32'h0000_0000 (nop).
  - D_PC = RESET_PC.
  - D_valid = 0.
  - stall_cnt = 0.
  - Reset overrides stall and flush. Reset mid-stall discards the held instruction.
- im_addr = (F_PC - IM_BASE)[IM_AW+1:2]. Upper bits are truncated, so addresses wrap modulo the memory size. No registered latency.
- Normal cycle (stall=0, flush=0):
  - F_PC <= F_nextPC.
  - D_instr <= im_rdata.
  - D_PC <= F_PC.
  - D_valid <= 1.
  - Fetch-to-D latency is one cycle.
- stall=1, flush=0:
  - F_PC, D_instr, D_PC and D_valid all hold.
  - stall_cnt increments and saturates at 32'hFFFF_FFFF.
- flush=1, stall=0:
  - D_instr <= 0, D_valid <= 0, D_PC <= F_PC.
  - F_PC <= F_nextPC; fetch continues.
- stall=1 and flush=1 together:
  - Flush wins on F/D: D_instr <= 0, D_valid <= 0, D_PC holds.
  - F_PC holds.
  - stall_cnt increments.
- Delay slot: the instruction after a branch is fetched normally. This block never squashes it on its own; only flush does.
- F_nextPC is not checked for alignment unless the optional feature is enabled; bits [1:0] are carried into F_PC unchanged.
- No internal FSM beyond these registers. The state is {F_PC, F/D register, stall_cnt}.

Optional Feature:
- Macro: IFU_ADEL_CHECK_EN.
- When defined:
  - Adds output D_exc_adel (1 bit).
  - At fetch, an address error is flagged if F_PC[1:0] != 0, or F_PC < IM_BASE, or F_PC >= IM_BASE + 4*2^IM_AW.
  - On an address error, D_instr is loaded with 0 instead of im_rdata, D_exc_adel <= 1, and D_valid <= 1.
  - D_exc_adel follows the same stall, flush and reset rules as D_valid (reset value 0, cleared by flush).
- When undefined: the port is absent and no check is performed.

Decomposition:
- Shared package/header (alongside the instruction-type defines): RESET_PC, IM_BASE, IM_AW defaults and the NOP encoding 32'h0.
- One sub-module is natural: fd_reg, the F/D pipeline register with en/clr. It is reused later for D/E, E/M and M/W.
- PC register and stall_cnt stay in the top level.

Test Plan:
- Reset: hold resetn=0 for 2 cycles, then release with F_nextPC=F_PC+4.
  - Expect F_PC = 0x3000, 0x3004, 0x3008.
  - Expect D_valid=0 then 1, and D_PC=0x3000 one cycle after release.
- Straight-line fetch: im_rdata = 0x3C011234 at F_PC=0x3000 -> next cycle D_instr=0x3C011234, D_PC=0x3000, im_addr=0x001.
- Stall: assert stall for 3 cycles at F_PC=0x3008.
  - Expect F_PC, D_instr and D_PC frozen, stall_cnt=3.
  - After release, F_PC=F_nextPC.
- Flush alone at D_PC=0x3004 -> next cycle D_instr=0, D_valid=0, and F_PC advances.
- Stall and flush together -> D_valid=0, D_instr=0, F_PC held, stall_cnt+1.
- Reset mid-stall: resetn=0 while stall=1 -> F_PC=0x3000, D_valid=0, stall_cnt=0.
- With IFU_ADEL_CHECK_EN:
  - F_nextPC=0x3002 -> next D has D_exc_adel=1 and D_instr=0.
  - F_nextPC=0x2FFC -> D_exc_adel=1.

Source files
------------

// File: rtl/ifu_fd_stage_pkg.sv
// ---------------------------------------------------------------------------
// ifu_fd_stage_pkg
// Shared constants for the fetch stage and the pipeline registers.
//   RESET_PC_DEF : fetch address loaded on reset
//   IM_BASE_DEF  : byte address of instruction-memory word 0
//   IM_AW_DEF    : instruction-memory word-address width
//   NOP_INSTR    : encoding used for bubbles and suppressed fetches
//   opcode_e     : primary opcode field values of the supported MIPS subset
// ---------------------------------------------------------------------------
package ifu_fd_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam int          IM_AW_DEF    = 12;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_ORI     = 6'h0D,
    OP_LUI     = 6'h0F,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2B
  } opcode_e;

endpackage

// File: rtl/ifu_fd_stage_fd_reg.sv
// ---------------------------------------------------------------------------
// fd_reg
// Generic pipeline register between two stages (used for F/D, and later for
// D/E, E/M and M/W).
//   clk, resetn         : clock, synchronous active-low reset
//   en                  : load a new entry (deasserted while the stage stalls)
//   clr                 : turn the entry into a bubble; wins over en
//   payload_i/payload_o : stage payload, cleared to all-zero on clr
//   pc_i/pc_o           : PC of the entry; loads whenever en=1, even on clr,
//                         and holds when en=0
//   valid_i/valid_o     : entry is a real instruction (0 = bubble)
// valid_o qualifies payload_o and pc_o; there is no backpressure other than
// en being held low.
// ---------------------------------------------------------------------------
module fd_reg
  import ifu_fd_stage_pkg::*;
#(
  parameter int          PW     = 32,
  parameter logic [31:0] RST_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic          clr,
  input  logic [PW-1:0] payload_i,
  input  logic [31:0]   pc_i,
  input  logic          valid_i,
  output logic [PW-1:0] payload_o,
  output logic [31:0]   pc_o,
  output logic          valid_o
);

  logic [PW-1:0] payload_q, payload_d;
  logic [31:0]   pc_q, pc_d;
  logic          valid_q, valid_d;

  always_comb begin
    payload_d = payload_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    if (clr) begin
      payload_d = '0;
      valid_d   = 1'b0;
      // A bubble still tracks the PC it replaced unless the stage is stalled.
      if (en) pc_d = pc_i;
    end else if (en) begin
      payload_d = payload_i;
      pc_d      = pc_i;
      valid_d   = valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      payload_q <= '0;
      pc_q      <= RST_PC;
      valid_q   <= 1'b0;
    end else begin
      payload_q <= payload_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
    end
  end

  assign payload_o = payload_q;
  assign pc_o      = pc_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/ifu_fd_stage.sv
// ---------------------------------------------------------------------------
// ifu_fd_stage
// Fetch-stage PC register plus the F/D pipeline register.
//   clk, resetn : clock, synchronous active-low reset
//   F_nextPC    : next fetch address from the next-PC logic
//   stall       : holds F_PC and the F/D register, counts in stall_cnt
//   flush       : replaces the instruction entering D with a bubble
//   im_addr     : instruction-memory word address, combinational from F_PC
//   im_rdata    : instruction word for im_addr, same cycle
//   F_PC        : current fetch PC
//   D_instr, D_PC, D_valid : instruction in D, its PC, real/bubble flag
//   stall_cnt   : saturating count of stalled cycles since reset
//   D_exc_adel  : fetch address error for the D instruction (only with
//                 IFU_ADEL_CHECK_EN defined)
// Optional feature macro: IFU_ADEL_CHECK_EN (fetch address-error check).
// ---------------------------------------------------------------------------
module ifu_fd_stage
  import ifu_fd_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter int          IM_AW    = IM_AW_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      F_nextPC,
  input  logic             stall,
  input  logic             flush,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      F_PC,
  output logic [31:0]      D_instr,
  output logic [31:0]      D_PC,
  output logic             D_valid,
`ifdef IFU_ADEL_CHECK_EN
  output logic             D_exc_adel,
`endif
  output logic [31:0]      stall_cnt
);

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] pc_off;
  logic        unused_pc_off;
  logic        fd_en;

  // Word address relative to the memory base; upper bits are dropped so
  // out-of-window addresses wrap modulo the memory size.
  assign pc_off        = f_pc_q - IM_BASE;
  assign im_addr       = pc_off[IM_AW+1:2];
  assign unused_pc_off = ^{pc_off[31:IM_AW+2], pc_off[1:0]};

  always_comb begin
    f_pc_d      = f_pc_q;
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      f_pc_d = F_nextPC;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      f_pc_q      <= RESET_PC;
      stall_cnt_q <= '0;
    end else begin
      f_pc_q      <= f_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign F_PC      = f_pc_q;
  assign stall_cnt = stall_cnt_q;
  assign fd_en     = ~stall;

`ifdef IFU_ADEL_CHECK_EN
  localparam int          PW       = 33;
  // One past the last valid byte address, kept 33 bits wide so a window at
  // the top of the address space does not overflow.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'd4 << IM_AW);

  logic          adel;
  logic [PW-1:0] fd_in, fd_out;

  always_comb begin
    adel  = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IM_BASE) ||
            ({1'b0, f_pc_q} >= IM_LIMIT);
    // A faulting fetch enters D as a valid nop carrying the error flag.
    fd_in = adel ? {1'b1, NOP_INSTR} : {1'b0, im_rdata};
  end

  assign D_instr    = fd_out[31:0];
  assign D_exc_adel = fd_out[32];
`else
  localparam int PW = 32;

  logic [PW-1:0] fd_in, fd_out;

  assign fd_in   = im_rdata;
  assign D_instr = fd_out;
`endif

  fd_reg #(
    .PW    (PW),
    .RST_PC(RESET_PC)
  ) u_fd_reg (
    .clk      (clk),
    .resetn   (resetn),
    .en       (fd_en),
    .clr      (flush),
    .payload_i(fd_in),
    .pc_i     (f_pc_q),
    .valid_i  (1'b1),
    .payload_o(fd_out),
    .pc_o     (D_PC),
    .valid_o  (D_valid)
  );

endmodule
